// File: rtl/note_voice_allocator_pkg.sv
// rtl/note_voice_allocator_pkg.sv - shared widths and constants for the note voice allocator
package note_voice_allocator_pkg;

    localparam int DEF_NUM_VOICES = 3;
    localparam int DEF_NOTE_W     = 6;
    localparam int DEF_DUR_W      = 6;
    localparam int NOTE_REST      = 0;

endpackage

// File: rtl/note_voice_allocator_voice_slot.sv
// rtl/note_voice_allocator_voice_slot.sv - one voice: note register, beat countdown, active/start flags
module voice_slot
    import note_voice_allocator_pkg::*;
#(
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int DUR_W  = DEF_DUR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_tick,
    input  logic              i_clear,
    input  logic [NOTE_W-1:0] i_note,
    input  logic [DUR_W-1:0]  i_dur,
    output logic [NOTE_W-1:0] o_note,
    output logic              o_active,
    output logic              o_start,
    output logic              o_expiring
);

    logic [NOTE_W-1:0] r_note;
    logic [DUR_W-1:0]  r_rem;
    logic              r_active;
    logic              r_start;
    logic              w_can_dec;

    assign w_can_dec  = i_tick & r_active & (r_rem != '0);
    assign o_expiring = w_can_dec & (r_rem == DUR_W'(1));

    // clear beats load beats tick; a freshly loaded voice skips this cycle's beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_note   <= NOTE_W'(NOTE_REST);
            r_rem    <= '0;
            r_active <= 1'b0;
            r_start  <= 1'b0;
        end else if (i_clear) begin
            r_note   <= NOTE_W'(NOTE_REST);
            r_rem    <= '0;
            r_active <= 1'b0;
            r_start  <= 1'b0;
        end else if (i_load) begin
            r_note   <= i_note;
            r_rem    <= i_dur;
            r_active <= 1'b1;
            r_start  <= 1'b1;
        end else begin
            r_start <= 1'b0;
            if (o_expiring) begin
                r_note   <= NOTE_W'(NOTE_REST);
                r_rem    <= '0;
                r_active <= 1'b0;
            end else if (w_can_dec) begin
                r_rem <= r_rem - DUR_W'(1);
            end
        end
    end

    assign o_note   = r_note;
    assign o_active = r_active;
    assign o_start  = r_start;

endmodule

// File: rtl/note_voice_allocator.sv
// rtl/note_voice_allocator.sv - accepts note/duration pairs and allocates them to free voice slots
module note_voice_allocator
    import note_voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         play,
    input  logic                         flush,
    input  logic                         beat,
    input  logic                         new_note,
    input  logic [NOTE_W-1:0]            note,
    input  logic [DUR_W-1:0]             duration,
    output logic                         player_available,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES-1:0]        voice_start
);

    logic                  r_avail;
    logic                  w_accept;
    logic                  w_alloc;
    logic                  w_tick;
    logic [NUM_VOICES-1:0] w_active;
    logic [NUM_VOICES-1:0] w_expiring;
    logic [NUM_VOICES-1:0] w_idle;
    logic [NUM_VOICES-1:0] w_pick;
    logic [NUM_VOICES-1:0] w_load;
    logic [NUM_VOICES-1:0] w_next_active;

    assign w_accept = new_note & r_avail & play;
    assign w_alloc  = w_accept & ~flush
                    & (note != NOTE_W'(NOTE_REST)) & (duration != '0);
    assign w_tick   = beat & play & ~flush;

    // lowest set bit of the pre-edge idle set, so a voice expiring this edge is never picked
    assign w_idle = ~w_active;
    assign w_pick = w_idle & (~w_idle + NUM_VOICES'(1));
    assign w_load = w_alloc ? w_pick : '0;

    assign w_next_active = flush ? '0 : ((w_active & ~w_expiring) | w_load);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_avail <= 1'b0;
        end else begin
            r_avail <= play & ~flush & (|(~w_next_active));
        end
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        voice_slot #(
            .NOTE_W (NOTE_W),
            .DUR_W  (DUR_W)
        ) u_slot (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_load     (w_load[i]),
            .i_tick     (w_tick),
            .i_clear    (flush),
            .i_note     (note),
            .i_dur      (duration),
            .o_note     (voice_note[i*NOTE_W +: NOTE_W]),
            .o_active   (w_active[i]),
            .o_start    (voice_start[i]),
            .o_expiring (w_expiring[i])
        );
    end

    assign player_available = r_avail;
    assign voice_active     = w_active;

endmodule

// File: tb/tb_note_voice_allocator.sv
// tb/tb_note_voice_allocator.sv - table-driven bench for note_voice_allocator
module tb_note_voice_allocator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        play, flush, beat, new_note;
    logic [5:0]  note, duration;
    logic        player_available;
    logic [17:0] voice_note;
    logic [2:0]  voice_active, voice_start;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        pl, fl, bt, nn;
        logic [5:0]  nt, du;
        logic        ea;
        logic [2:0]  eact, est;
        logic [17:0] enotes;
    } vec_t;

    vec_t tbl[$];

    note_voice_allocator dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .play             (play),
        .flush            (flush),
        .beat             (beat),
        .new_note         (new_note),
        .note             (note),
        .duration         (duration),
        .player_available (player_available),
        .voice_note       (voice_note),
        .voice_active     (voice_active),
        .voice_start      (voice_start)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] nn3(input int n2, input int n1, input int n0);
        return {6'(n2), 6'(n1), 6'(n0)};
    endfunction

    task automatic add(input logic pl, input logic fl, input logic bt, input logic nn,
                       input int nt, input int du, input logic ea,
                       input logic [2:0] eact, input logic [2:0] est, input logic [17:0] en);
        vec_t v;
        v.pl = pl; v.fl = fl; v.bt = bt; v.nn = nn;
        v.nt = 6'(nt); v.du = 6'(du);
        v.ea = ea; v.eact = eact; v.est = est; v.enotes = en;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ea, input logic [2:0] eact,
                           input logic [2:0] est, input logic [17:0] en);
        chk({tag, " avail"},  32'(player_available), 32'(ea));
        chk({tag, " active"}, 32'(voice_active),     32'(eact));
        chk({tag, " start"},  32'(voice_start),      32'(est));
        chk({tag, " notes"},  32'(voice_note),       32'(en));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pl, input logic fl, input logic bt, input logic nn,
                         input int nt, input int du);
        play = pl; flush = fl; beat = bt; new_note = nn;
        note = 6'(nt); duration = 6'(du);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // post-reset idle, then note 12 for 2 beats plus one extra beat
        add(1,0,0,0, 0,0,  1, 3'b000, 3'b000, nn3(0,0,0));
        add(1,0,0,1,12,2,  1, 3'b001, 3'b001, nn3(0,0,12));
        add(1,0,0,0, 0,0,  1, 3'b001, 3'b000, nn3(0,0,12));
        add(1,0,1,0, 0,0,  1, 3'b001, 3'b000, nn3(0,0,12));
        add(1,0,1,0, 0,0,  1, 3'b000, 3'b000, nn3(0,0,0));
        add(1,0,1,0, 0,0,  1, 3'b000, 3'b000, nn3(0,0,0));
        // fill all three voices; fourth note ignored
        add(1,0,0,1, 5,4,  1, 3'b001, 3'b001, nn3(0,0,5));
        add(1,0,0,1, 9,4,  1, 3'b011, 3'b010, nn3(0,9,5));
        add(1,0,0,1,13,4,  0, 3'b111, 3'b100, nn3(13,9,5));
        add(1,0,0,1,15,4,  0, 3'b111, 3'b000, nn3(13,9,5));
        add(1,0,1,0, 0,0,  0, 3'b111, 3'b000, nn3(13,9,5));
        add(1,0,1,0, 0,0,  0, 3'b111, 3'b000, nn3(13,9,5));
        add(1,0,1,0, 0,0,  0, 3'b111, 3'b000, nn3(13,9,5));
        add(1,0,1,0, 0,0,  1, 3'b000, 3'b000, nn3(0,0,0));
        // voice 1 expires first, freed slot takes note 20
        add(1,0,0,1,30,3,  1, 3'b001, 3'b001, nn3(0,0,30));
        add(1,0,0,1,31,1,  1, 3'b011, 3'b010, nn3(0,31,30));
        add(1,0,0,1,32,3,  0, 3'b111, 3'b100, nn3(32,31,30));
        add(1,0,1,0, 0,0,  1, 3'b101, 3'b000, nn3(32,0,30));
        add(1,0,0,1,20,1,  0, 3'b111, 3'b010, nn3(32,20,30));
        add(1,0,1,0, 0,0,  1, 3'b101, 3'b000, nn3(32,0,30));
        add(1,0,1,0, 0,0,  1, 3'b000, 3'b000, nn3(0,0,0));
        // load in the same cycle as a beat is not decremented
        add(1,0,1,1,40,1,  1, 3'b001, 3'b001, nn3(0,0,40));
        add(1,0,1,0, 0,0,  1, 3'b000, 3'b000, nn3(0,0,0));
        // rest and zero duration allocate nothing
        add(1,0,0,1, 0,3,  1, 3'b000, 3'b000, nn3(0,0,0));
        add(1,0,0,1, 7,0,  1, 3'b000, 3'b000, nn3(0,0,0));
        // voice 0 expiring on the acceptance edge is not reused
        add(1,0,0,1, 1,1,  1, 3'b001, 3'b001, nn3(0,0,1));
        add(1,0,0,1, 2,5,  1, 3'b011, 3'b010, nn3(0,2,1));
        add(1,0,1,1, 3,5,  1, 3'b110, 3'b100, nn3(3,2,0));
        // flush overrides acceptance and beat
        add(1,1,1,1, 9,2,  0, 3'b000, 3'b000, nn3(0,0,0));
        add(1,0,0,0, 0,0,  1, 3'b000, 3'b000, nn3(0,0,0));
        // pause holds a note through 10 beats
        add(1,0,0,1, 3,2,  1, 3'b001, 3'b001, nn3(0,0,3));
        for (int k = 0; k < 10; k++)
            add(0,0,1,0, 0,0,  0, 3'b001, 3'b000, nn3(0,0,3));
        add(1,0,0,0, 0,0,  1, 3'b001, 3'b000, nn3(0,0,3));
        add(1,0,1,0, 0,0,  1, 3'b001, 3'b000, nn3(0,0,3));
        add(1,0,1,0, 0,0,  1, 3'b000, 3'b000, nn3(0,0,0));

        step();
        step();
        chk_all("reset", 1'b0, 3'b000, 3'b000, nn3(0,0,0));
        reset_n = 1'b1;
        play    = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].pl, tbl[i].fl, tbl[i].bt, tbl[i].nn, int'(tbl[i].nt), int'(tbl[i].du));
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eact, tbl[i].est, tbl[i].enotes);
        end

        // async reset mid-note clears everything before the next edge
        drive(1, 0, 0, 1, 11, 3);
        step();
        drive(1, 0, 0, 1, 12, 3);
        step();
        chk_all("preload", 1'b1, 3'b011, 3'b010, nn3(0,12,11));
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 3'b000, 3'b000, nn3(0,0,0));
        step();
        chk_all("rst_hold", 1'b0, 3'b000, 3'b000, nn3(0,0,0));
        reset_n = 1'b1;
        step();
        chk_all("rst_release", 1'b1, 3'b000, 3'b000, nn3(0,0,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_voice_allocator.md
# note_voice_allocator

Receiving end of the song-reader note interface. Accepts `note`/`duration` pairs on the `new_note`/`player_available` handshake, assigns each to a free voice slot, and counts its remaining length in beats. It drives per-voice note codes and pulses to the chord/synth stage. It frees slots on their own as notes expire, so the reader can stack overlapping notes into chords.

## Interface
Parameters:
- `NUM_VOICES`, 3, number of simultaneous voice slots (1–8)
- `NOTE_W`, 6, note code width
- `DUR_W`, 6, duration width in beats

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  one clock; reset is asynchronous and active-low
- `play`  in  1  1 = running; 0 = paused (counters hold, no acceptance)
- `flush`  in  1  song end from control; clears all voices
- `beat`  in  1  single-cycle beat strobe
- `new_note`  in  1  sender valid; sampled only when `player_available`=1
- `note`  in  NOTE_W  note code; 0 = rest
- `duration`  in  DUR_W  length in beats
- `player_available`  out  1  registered ready to the sender
- `voice_note`  out  NUM_VOICES*NOTE_W  note code of voice i at bits [i*NOTE_W +: NOTE_W]; 0 when idle
- `voice_active`  out  NUM_VOICES  voice i holds a sounding note
- `voice_start`  out  NUM_VOICES  one-cycle pulse, the cycle after voice i is loaded

## Operation
- Acceptance happens when `new_note` & `player_available` are both 1 in the same cycle. `new_note` while `player_available`=0 is ignored with no state change.
- An accepted note with `note`≠0 and `duration`≠0 loads the lowest-index idle voice:
  - `voice_note`[i] ← `note`
  - remaining[i] ← `duration`
  - `voice_active`[i] ← 1
  - `voice_start`[i] ← 1
- An accepted rest (`note`=0) or `duration`=0 completes the handshake but allocates nothing.
- On `beat` & `play`, every active voice decrements remaining. A voice whose remaining is 1 at that beat goes idle on the next edge: `voice_active`→0 and `voice_note`→0.
- If a voice is loaded in the same cycle as a beat, it is not decremented that cycle. Other voices decrement normally.
- A voice expiring on the same edge as an acceptance cannot be chosen for that acceptance. Allocation uses the pre-edge idle set.
- `player_available` is registered each edge as: `play` & ¬`flush` & (at least one voice idle in the next state).
- `flush`=1 on an edge idles all voices and zeroes remaining and `voice_note`. It overrides a simultaneous acceptance and beat. `voice_start` is 0.
- While `play`=0, all counters, notes and active flags hold, and `player_available` is 0 from the next edge.
- Remaining counters are unsigned DUR_W and never wrap: decrement applies only to active voices with remaining ≥ 1.

## Timing
- Reset (async assert, sync release): all outputs 0, all voices idle. `player_available` rises on the first edge after release when `play`=1.
- Latency:
  - acceptance → `voice_active`/`voice_note`/`voice_start` visible: 1 cycle.
  - expiring beat → voice idle: 1 cycle.
- `player_available` lags state by one edge. After filling the last idle voice it drops the following cycle, so back-to-back `new_note` in consecutive cycles is accepted only while a voice is still idle pre-edge. If the sender does issue a second `new_note` on that cycle, the note is ignored.
- A note of duration D loaded before beat k is active through beat k+D-1 and idle the cycle after that beat.
- `reset_n` asserted mid-note clears everything immediately. There is no partial state.

## Structure
- Shared package: `NOTE_W`, `DUR_W`, `NOTE_REST` (=0), default `NUM_VOICES`.
- Sub-module `voice_slot`, instantiated NUM_VOICES times. Each slot holds the note register, the remaining counter and the active and start flags, with `load`, `tick` and `clear` inputs.
- The top level holds the priority encoder (lowest idle index), the free-voice reduction and the `player_available` register.

## Test plan
- Reset released, `play`=1, send note 12 with duration 2, then 3 beats → `voice_start`[0] pulses 1 cycle after acceptance; `voice_note`[0]=12; idle the cycle after beat 2.
- Send three notes (5/4, 9/4, 13/4) with no beats between → voices 0, 1, 2 loaded; `player_available`=0 after the third; a fourth `new_note` is ignored.
- With all voices busy, voice 1 expires on a beat → `player_available` returns 1 next cycle; the next note (20/1) lands in voice 1.
- Send a rest (0/3) and a zero-duration note (7/0) → handshake completes; all `voice_active` stay 0.
- Load note 3/2, drop `play` for 10 beats, then restore → `voice_active`[0] stays 1 through the pause and expires after 2 further beats.
- Assert `flush` in the same cycle as an acceptance and a beat with 2 voices active → all voices idle next cycle and no `voice_start`. Repeat with `reset_n` asserted asynchronously mid-cycle → outputs 0 immediately.
